// File: rtl/c17_bist_ctrl_if.sv
// rtl/c17_bist_ctrl_if.sv - stimulus/response and status bundle of the c17 BIST controller
interface c17_bist_ctrl_if;
   logic       start;
   logic [4:0] pat_out;
   logic [1:0] resp_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] signature;

   modport master (
      output start, resp_in,
      input  pat_out, busy, done, pass, signature
   );

   modport slave (
      input  start, resp_in,
      output pat_out, busy, done, pass, signature
   );
endinterface

// File: rtl/c17_bist_ctrl.sv
// rtl/c17_bist_ctrl.sv - LFSR stimulus, MISR compaction and golden compare around the c17 netlist
module c17_bist_ctrl #(
   parameter int         NUM_PATTERNS = 31,
   parameter logic [4:0] LFSR_SEED    = 5'b00001,
   parameter int         RESP_DELAY   = 0,
   parameter logic [7:0] GOLDEN_SIG   = 8'h00
) (
   input logic            clk,
   input logic            rst_n,
   c17_bist_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t     state;
   logic [4:0] lfsr;
   logic [4:0] pat;
   logic [7:0] count;
   logic [7:0] misr;
   logic [1:0] vpipe;
   logic       busy;
   logic       done;
   logic       pass;

   logic       run;
   logic [2:0] vflags;
   logic       capture;
   logic [7:0] misr_shift;
   logic [7:0] misr_next;
   logic       last_pat;
   logic       flush_end;

   function automatic logic [4:0] lfsr_step(input logic [4:0] q);
      return {q[3:0], q[4] ^ q[2]};
   endfunction

   always_comb begin
      run        = (state == RUN);
      vflags     = {vpipe, run};
      capture    = vflags[2'(RESP_DELAY)];
      misr_shift = {misr[6:0], 1'b0} ^ (misr[7] ? 8'h1D : 8'h00);
      misr_next  = capture ? (misr_shift ^ {6'b0, bus.resp_in}) : misr;
      last_pat   = (count == 8'(NUM_PATTERNS - 1));
      flush_end  = (count == 8'(RESP_DELAY - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         lfsr  <= LFSR_SEED;
         pat   <= '0;
         count <= '0;
         misr  <= '0;
         vpipe <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
      end else begin
         vpipe <= {vpipe[0], run};
         misr  <= misr_next;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               pat <= '0;
               if (bus.start) begin
                  pat   <= LFSR_SEED;
                  lfsr  <= lfsr_step(LFSR_SEED);
                  count <= '0;
                  misr  <= '0;
                  pass  <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               lfsr  <= lfsr_step(lfsr);
               pat   <= lfsr;
               count <= count + 8'd1;
               if (last_pat) begin
                  pat   <= '0;
                  count <= '0;
                  if (RESP_DELAY == 0) begin
                     // Last capture lands on this same edge, so judge the updated signature.
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (misr_next == GOLDEN_SIG);
                  end else begin
                     state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               count <= count + 8'd1;
               if (flush_end) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (misr_next == GOLDEN_SIG);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.pat_out   = pat;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.pass      = pass;
   assign bus.signature = misr;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// tb/tb_c17_bist_ctrl.sv - directed bench for c17_bist_ctrl
module tb_c17_bist_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic a_c17;
   logic [4:0] pd1, pd2;
   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   c17_bist_ctrl_if if_a ();
   c17_bist_ctrl_if if_b ();
   c17_bist_ctrl_if if_c ();
   c17_bist_ctrl_if if_d ();
   c17_bist_ctrl_if if_e ();

   c17_bist_ctrl #(.NUM_PATTERNS(4), .RESP_DELAY(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   c17_bist_ctrl #(.NUM_PATTERNS(3), .RESP_DELAY(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   c17_bist_ctrl #(.NUM_PATTERNS(9), .RESP_DELAY(0)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
   c17_bist_ctrl #(.NUM_PATTERNS(3), .RESP_DELAY(2)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));
   c17_bist_ctrl #(.NUM_PATTERNS(3), .RESP_DELAY(0)) u_e (.clk(clk), .rst_n(rst_n), .bus(if_e));

   // pat[4:0] = N1,N2,N3,N6,N7; result {N22,N23}
   function automatic logic [1:0] c17(input logic [4:0] p);
      logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
      {n1, n2, n3, n6, n7} = p;
      n10 = ~(n1 & n3);
      n11 = ~(n3 & n6);
      n16 = ~(n2 & n11);
      n19 = ~(n11 & n7);
      return {~(n10 & n16), ~(n16 & n19)};
   endfunction

   assign if_a.resp_in = a_c17 ? c17(if_a.pat_out) : 2'b00;
   assign if_b.resp_in = 2'b01;
   assign if_c.resp_in = 2'b01;
   assign if_d.resp_in = c17(pd2);
   assign if_e.resp_in = c17(if_e.pat_out);

   always @(posedge clk) begin
      pd1 <= if_d.pat_out;
      pd2 <= pd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [4:0] exp_pat [4] = '{5'h01, 5'h02, 5'h04, 5'h09};
   logic [7:0] exp_b   [3] = '{8'h01, 8'h03, 8'h07};
   logic [7:0] exp_c   [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hE2};

   initial begin
      rst_n = 1'b1;
      a_c17 = 1'b0;
      if_a.start = 1'b0;
      if_b.start = 1'b0;
      if_c.start = 1'b0;
      if_d.start = 1'b0;
      if_e.start = 1'b0;
      #2 rst_n = 1'b0;
      step(); step(); step();
      rst_n = 1'b1;

      for (int k = 0; k < 4; k++) begin
         step();
         chk("rst_pat",  8'(if_a.pat_out), 8'h00);
         chk("rst_busy", 8'(if_a.busy),    8'h00);
         chk("rst_done", 8'(if_a.done),    8'h00);
         chk("rst_pass", 8'(if_a.pass),    8'h00);
         chk("rst_sig",  if_a.signature,   8'h00);
      end

      // pattern sequence, NUM_PATTERNS=4, resp_in=0
      if_a.start = 1'b1;
      step();
      if_a.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("seq_pat",  8'(if_a.pat_out), 8'(exp_pat[i]));
         chk("seq_busy", 8'(if_a.busy),    8'h01);
         chk("seq_done", 8'(if_a.done),    8'h00);
         step();
      end
      chk("seq_done_pulse", 8'(if_a.done), 8'h01);
      chk("seq_busy_off",   8'(if_a.busy), 8'h00);
      chk("seq_sig",        if_a.signature, 8'h00);
      chk("seq_pass",       8'(if_a.pass), 8'h01);
      step();
      chk("seq_done_once",  8'(if_a.done), 8'h00);
      chk("seq_pass_hold",  8'(if_a.pass), 8'h01);

      // MISR arithmetic, resp 01
      if_b.start = 1'b1;
      step();
      if_b.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("misr3_sig", if_b.signature, exp_b[i]);
      end
      chk("misr3_done", 8'(if_b.done), 8'h01);
      chk("misr3_pass", 8'(if_b.pass), 8'h00);

      // MISR feedback across bit 7
      if_c.start = 1'b1;
      step();
      if_c.start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         step();
         chk("misr9_sig", if_c.signature, exp_c[i]);
      end
      chk("misr9_done", 8'(if_c.done), 8'h01);
      step();
      chk("misr9_hold", if_c.signature, 8'hE2);

      // delayed responses with flush vs undelayed reference run
      if_d.start = 1'b1;
      if_e.start = 1'b1;
      step();
      if_d.start = 1'b0;
      if_e.start = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         step();
         chk("dly_done_d", 8'(if_d.done), 8'(k == 6));
         chk("dly_done_e", 8'(if_e.done), 8'(k == 4));
         if (k == 4) chk("dly_sig_e", if_e.signature, 8'h04);
         if (k >= 4 && k <= 5) chk("dly_flush_busy", 8'(if_d.busy), 8'h01);
      end
      chk("dly_sig_d",  if_d.signature, 8'h04);
      chk("dly_pass_d", 8'(if_d.pass), 8'h00);

      // start re-pulsed mid-run and during DONE
      a_c17 = 1'b1;
      if_a.start = 1'b1;
      step();
      if_a.start = 1'b0;
      step();
      if_a.start = 1'b1;
      step();
      if_a.start = 1'b0;
      chk("rep_pat2", 8'(if_a.pat_out), 8'h04);
      step();
      chk("rep_pat3", 8'(if_a.pat_out), 8'h09);
      step();
      chk("rep_done", 8'(if_a.done), 8'h01);
      chk("rep_sig",  if_a.signature, 8'h0B);
      chk("rep_pass", 8'(if_a.pass), 8'h00);
      if_a.start = 1'b1;
      step();
      if_a.start = 1'b0;
      step();
      chk("rep_done_ign_busy", 8'(if_a.busy), 8'h00);
      chk("rep_done_ign_sig",  if_a.signature, 8'h0B);

      // reset mid-run
      if_a.start = 1'b1;
      step();
      if_a.start = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("mrst_pat",  8'(if_a.pat_out), 8'h00);
      chk("mrst_busy", 8'(if_a.busy),    8'h00);
      chk("mrst_sig",  if_a.signature,   8'h00);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("mrst_no_done", 8'(if_a.done), 8'h00);
         chk("mrst_idle",    8'(if_a.busy), 8'h00);
      end

      // clean run after reset
      if_a.start = 1'b1;
      step();
      if_a.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("clean_pat", 8'(if_a.pat_out), 8'(exp_pat[i]));
         step();
      end
      chk("clean_done", 8'(if_a.done), 8'h01);
      chk("clean_sig",  if_a.signature, 8'h0B);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
